// File: rtl/led_frame_builder.sv
// Turns a set of per-bin LED counts into a fixed-length stream of LEDS LEDs.
// Bins are emitted in ascending order, then the stream is padded with blanks. Output moves only on a ready handshake.
module led_frame_builder #(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [BIN_QTY-1:0][$clog2(LEDS)-1:0]    LEDCount_i,
  input  logic                                    data_v_i,
  input  logic                                    ready_i,
  output logic                                    ledValid_o,
  output logic [$clog2(BIN_QTY)-1:0]              ledBin_o,
  output logic                                    ledBlank_o,
  output logic                                    frameStart_o,
  output logic                                    frameEnd_o,
  output logic                                    busy_o,
  output logic                                    dropped_o
);

  localparam int CW = $clog2(LEDS);
  localparam int BW = $clog2(BIN_QTY);
  localparam int PW = $clog2(LEDS) + 1;
  localparam logic [PW-1:0] LAST = PW'(LEDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t                       state_r, state_s;
  logic [BIN_QTY-1:0][CW-1:0]   rem_r, rem_s;
  logic [PW-1:0]                pos_r, pos_s;
  logic                         valid_s, blank_s, start_s, end_s, dropped_s;
  logic [BW-1:0]                bin_s;
  logic [BW:0]                  hit_in_s, hit_rem_s;

  // {found, index} of the lowest-numbered bin with a nonzero count.
  function automatic logic [BW:0] first_nz(input logic [BIN_QTY-1:0][CW-1:0] c);
    logic [BW:0] r;
    r = {(BW+1){1'b0}};
    for (int i = BIN_QTY - 1; i >= 0; i--) begin
      if (c[i] != {CW{1'b0}}) begin
        r = {1'b1, BW'(i)};
      end
    end
    return r;
  endfunction

  assign hit_in_s  = first_nz(LEDCount_i);
  assign hit_rem_s = first_nz(rem_r);

  // rem_r holds what is left after the LED currently on the outputs.
  // Each step therefore picks the next LED straight from rem_r, so zero-count bins never cost a cycle.
  always_comb begin
    state_s   = state_r;
    rem_s     = rem_r;
    pos_s     = pos_r;
    valid_s   = ledValid_o;
    bin_s     = ledBin_o;
    blank_s   = ledBlank_o;
    start_s   = frameStart_o;
    end_s     = frameEnd_o;
    dropped_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (data_v_i) begin
          pos_s   = {PW{1'b0}};
          valid_s = 1'b1;
          start_s = 1'b1;
          end_s   = (LAST == {PW{1'b0}});
          rem_s   = LEDCount_i;
          if (hit_in_s[BW]) begin
            state_s = EMIT;
            rem_s[hit_in_s[BW-1:0]] = LEDCount_i[hit_in_s[BW-1:0]] - CW'(1);
            bin_s   = hit_in_s[BW-1:0];
            blank_s = 1'b0;
          end else begin
            state_s = PAD;
            bin_s   = {BW{1'b0}};
            blank_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      EMIT, PAD: begin
        dropped_s = data_v_i;
        if (ready_i) begin
          if (pos_r == LAST) begin
            state_s = IDLE;
            valid_s = 1'b0;
            bin_s   = {BW{1'b0}};
            blank_s = 1'b0;
            start_s = 1'b0;
            end_s   = 1'b0;
          end else begin
            pos_s   = pos_r + PW'(1);
            start_s = 1'b0;
            end_s   = ((pos_r + PW'(1)) == LAST);
            if (hit_rem_s[BW]) begin
              state_s = EMIT;
              rem_s[hit_rem_s[BW-1:0]] = rem_r[hit_rem_s[BW-1:0]] - CW'(1);
              bin_s   = hit_rem_s[BW-1:0];
              blank_s = 1'b0;
            end else begin
              state_s = PAD;
              bin_s   = {BW{1'b0}};
              blank_s = 1'b1;
            end
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rem_r        <= '0;
      pos_r        <= {PW{1'b0}};
      ledValid_o   <= 1'b0;
      ledBin_o     <= {BW{1'b0}};
      ledBlank_o   <= 1'b0;
      frameStart_o <= 1'b0;
      frameEnd_o   <= 1'b0;
      busy_o       <= 1'b0;
      dropped_o    <= 1'b0;
    end else begin
      state_r      <= state_s;
      rem_r        <= rem_s;
      pos_r        <= pos_s;
      ledValid_o   <= valid_s;
      ledBin_o     <= bin_s;
      ledBlank_o   <= blank_s;
      frameStart_o <= start_s;
      frameEnd_o   <= end_s;
      busy_o       <= (state_s != IDLE);
      dropped_o    <= dropped_s;
    end
  end

endmodule

// File: doc/led_frame_builder.md
LED_FRAME_BUILDER -- requirements
Module: led_frame_builder

Interface
REQ-001 Parameter LEDS, default 50: LEDs per frame; the per-bin counts are meant to sum to this.
REQ-002 Parameter BIN_QTY, default 12: number of note bins.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 LEDCount_i  input  [BIN_QTY-1:0][$clog2(LEDS)-1:0]  per-bin LED counts.
REQ-006 data_v_i  input  1  LEDCount_i valid this cycle (single-cycle pulse).
REQ-007 ready_i  input  1  downstream LED driver accepts the current LED this cycle.
REQ-008 ledValid_o  output  1  ledBin_o/ledBlank_o hold a valid LED.
REQ-009 ledBin_o  output  [$clog2(BIN_QTY)-1:0]  bin index owning the current LED.
REQ-010 ledBlank_o  output  1  current LED is padding (unlit); ledBin_o = 0 when set.
REQ-011 frameStart_o  output  1  current LED is position 0 of the frame.
REQ-012 frameEnd_o  output  1  current LED is position LEDS-1 of the frame.
REQ-013 busy_o  output  1  a frame is in progress.
REQ-014 dropped_o  output  1  one-cycle pulse: data_v_i was ignored because busy.

Function
REQ-015 States: IDLE, EMIT, PAD; reset state IDLE.
REQ-016 IDLE with data_v_i=1 -> latch LEDCount_i, clear position counter; next cycle is EMIT, with ledValid_o=1 and frameStart_o=1.
REQ-017 Transfer: ledValid_o & ready_i at posedge; each transfer advances the position counter by exactly 1.
REQ-018 While ledValid_o=1 and ready_i=0, all LED outputs hold their values.
REQ-019 EMIT order: ascending bin index; bin i yields LEDCount[i] consecutive LEDs with ledBin_o=i.
REQ-020 Zero-count bins are skipped with no bubble cycle; ledValid_o stays high across bin changes.
REQ-021 Sum of counts > LEDS: output truncates at position LEDS-1; the remaining counts are discarded.
REQ-022 EMIT -> PAD when all bins are exhausted and position < LEDS.
REQ-023 PAD: ledBlank_o=1, ledBin_o=0 until position LEDS-1 is transferred.
REQ-024 All counts zero: IDLE -> PAD directly; the frame is 50 blanks at default LEDS.
REQ-025 frameEnd_o=1 on position LEDS-1 only; frameStart_o=1 on position 0 only.
REQ-026 Exactly LEDS transfers per frame, regardless of the count sum.
REQ-027 After the frameEnd transfer, the next cycle is IDLE with ledValid_o=0 and busy_o=0.
REQ-028 busy_o=1 in EMIT/PAD, and from the latch cycle until return to IDLE.
REQ-029 data_v_i=1 while busy_o=1, including the final-transfer cycle -> input ignored, latched counts unchanged, dropped_o=1 the next cycle.
REQ-030 Per-bin remaining-count and position counters are wide enough for LEDS without overflow; the position counter never wraps within a frame.

Reset
REQ-031 rst=1 at posedge -> next cycle state IDLE, and ledValid_o, ledBin_o, ledBlank_o, frameStart_o, frameEnd_o, busy_o, dropped_o all 0.
REQ-032 rst has priority over data_v_i and ready_i in the same cycle.
REQ-033 rst mid-frame aborts the frame with no further LEDs; the next data_v_i starts a fresh frame at position 0.

Verification (LEDS=50, BIN_QTY=12)
REQ-034 Counts 4 for bins 0-10, bin11=6, ready_i=1 -> 4 LEDs each of bins 0..10 then 6 of bin11; 50 transfers in 50 consecutive cycles; no blank; frameStart on LED 0, frameEnd on LED 49.
REQ-035 All counts 4 (sum 48) -> 48 bin LEDs in order, then 2 LEDs with ledBlank_o=1 and ledBin_o=0; frameEnd on the 2nd blank.
REQ-036 bin0=49, bin1=49, others 0 -> 49 LEDs of bin0, 1 LED of bin1 carrying frameEnd; no blank.
REQ-037 All counts 0 -> 50 blank LEDs; bin LEDs never appear.
REQ-038 bin0=0, bin5=25, others 0, ready_i toggling 1/0 -> outputs stable while ready_i=0; no bubble at the skipped bins; 25 bin5 then 25 blank; a data_v_i pulse mid-frame -> dropped_o pulse and an unchanged sequence.
REQ-039 rst asserted after the 10th transfer -> all outputs 0 next cycle; a subsequent data_v_i with all counts 4 yields a complete fresh 50-LED frame starting with frameStart_o.
